// File: rtl/vram_oam_arbiter.sv
// VRAM / OAM port arbiter.
// Shares the single-ported VRAM and OAM between the CPU bus, the PPU fetch/scan
// logic and OAM DMA, applying the LCD mode locks. The CPU side runs a small
// four-state access FSM; PPU and DMA requests drive the ports in the same cycle.
module vram_oam_arbiter #(
    parameter int VRAM_AW = 13,
    parameter int OAM_AW  = 8,
    parameter int DW      = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               lcd_en_in,
    input  logic [1:0]         ppu_mode_in,
    // CPU bus
    input  logic               cpu_req_in,
    input  logic               cpu_we_in,
    input  logic [15:0]        cpu_addr_in,
    input  logic [DW-1:0]      cpu_wdata_in,
    output logic               cpu_ack_out,
    output logic [DW-1:0]      cpu_rdata_out,
    // PPU VRAM fetch
    input  logic               ppu_vram_req_in,
    input  logic [VRAM_AW-1:0] ppu_vram_addr_in,
    output logic               ppu_vram_valid_out,
    output logic [DW-1:0]      ppu_vram_data_out,
    // PPU OAM scan
    input  logic               ppu_oam_req_in,
    input  logic [OAM_AW-1:0]  ppu_oam_addr_in,
    output logic               ppu_oam_valid_out,
    output logic [DW-1:0]      ppu_oam_data_out,
    // OAM DMA
    input  logic               dma_req_in,
    input  logic [OAM_AW-1:0]  dma_addr_in,
    input  logic [DW-1:0]      dma_wdata_in,
    // VRAM port
    output logic               vram_en_out,
    output logic               vram_we_out,
    output logic [VRAM_AW-1:0] vram_addr_out,
    output logic [DW-1:0]      vram_wdata_out,
    input  logic [DW-1:0]      vram_rdata_in,
    // OAM port
    output logic               oam_en_out,
    output logic               oam_we_out,
    output logic [OAM_AW-1:0]  oam_addr_out,
    output logic [DW-1:0]      oam_wdata_out,
    input  logic [DW-1:0]      oam_rdata_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } cpu_state_t;

    // Only the first 160 OAM bytes exist; everything above reads as open bus.
    localparam logic [OAM_AW-1:0] OAM_SIZE   = OAM_AW'(160);
    localparam logic [DW-1:0]     RD_BLOCKED = {DW{1'b1}};

    cpu_state_t         state_q, state_d;
    logic [15:0]        cpu_addr_q, cpu_addr_d;
    logic               cpu_we_q, cpu_we_d;
    logic [DW-1:0]      cpu_wdata_q, cpu_wdata_d;
    logic               blocked_q, blocked_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               ppu_vram_valid_q;
    logic               ppu_oam_valid_q;
    logic               ppu_oam_oob_q;

    logic               vram_lock;
    logic               oam_lock;
    logic               cpu_hits_vram;
    logic               cpu_hits_oam;
    logic [VRAM_AW-1:0] cpu_vram_addr;
    logic [OAM_AW-1:0]  cpu_oam_addr;
    logic               cpu_blocked_now;
    logic               cpu_port_busy;
    logic               cpu_vram_go;
    logic               cpu_oam_go;

    logic               ppu_vram_gnt;
    logic               dma_gnt;
    logic               ppu_oam_win;
    logic               ppu_oam_gnt;

    // Mode locks: VRAM is closed in Draw, OAM in OAMScan/Draw and while DMA runs.
    assign vram_lock = lcd_en_in & (ppu_mode_in == 2'd3);
    assign oam_lock  = dma_req_in | (lcd_en_in & ppu_mode_in[1]);

    // CPU address decode on the latched access.
    assign cpu_hits_vram = (cpu_addr_q[15:13] == 3'b100);
    assign cpu_hits_oam  = (cpu_addr_q[15:8] == 8'hFE) && (cpu_addr_q[7:0] < 8'd160);
    assign cpu_vram_addr = cpu_addr_q[VRAM_AW-1:0];
    assign cpu_oam_addr  = OAM_AW'(cpu_addr_q[7:0]);

    // Same-cycle grants for the higher-priority requesters; nothing reaches a
    // memory port while reset is held.
    assign ppu_vram_gnt = ~rst_in & ppu_vram_req_in;
    assign dma_gnt      = ~rst_in & dma_req_in & (dma_addr_in < OAM_SIZE);
    assign ppu_oam_win  = ~rst_in & ppu_oam_req_in & ~dma_req_in;
    assign ppu_oam_gnt  = ppu_oam_win & (ppu_oam_addr_in < OAM_SIZE);

    // Unmapped targets are treated exactly like locked ones.
    assign cpu_blocked_now = ~(cpu_hits_vram | cpu_hits_oam)
                           | (cpu_hits_vram & vram_lock)
                           | (cpu_hits_oam & oam_lock);
    assign cpu_port_busy   = (cpu_hits_vram & ppu_vram_gnt)
                           | (cpu_hits_oam & (dma_gnt | ppu_oam_gnt));

    // CPU access FSM: next state, latched request fields and completion data.
    always_comb begin
        state_d     = state_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_we_d    = cpu_we_q;
        cpu_wdata_d = cpu_wdata_q;
        blocked_d   = blocked_q;
        rdata_d     = rdata_q;
        cpu_vram_go = 1'b0;
        cpu_oam_go  = 1'b0;
        cpu_ack_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_in) begin
                    cpu_addr_d  = cpu_addr_in;
                    cpu_we_d    = cpu_we_in;
                    cpu_wdata_d = cpu_wdata_in;
                    blocked_d   = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The lock is checked before the grant so a lock arriving in the
                // grant cycle still blocks the access.
                if (cpu_blocked_now) begin
                    blocked_d = 1'b1;
                    state_d   = S_WAIT;
                end else if (!cpu_port_busy) begin
                    cpu_vram_go = cpu_hits_vram;
                    cpu_oam_go  = cpu_hits_oam;
                    blocked_d   = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (blocked_q || cpu_we_q) begin
                    rdata_d = RD_BLOCKED;
                end else if (cpu_hits_vram) begin
                    rdata_d = vram_rdata_in;
                end else begin
                    rdata_d = oam_rdata_in;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                cpu_ack_out = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // VRAM port mux: PPU fetch wins over the CPU.
    always_comb begin
        vram_en_out    = 1'b0;
        vram_we_out    = 1'b0;
        vram_addr_out  = '0;
        vram_wdata_out = '0;
        if (ppu_vram_gnt) begin
            vram_en_out   = 1'b1;
            vram_addr_out = ppu_vram_addr_in;
        end else if (cpu_vram_go) begin
            vram_en_out    = 1'b1;
            vram_we_out    = cpu_we_q;
            vram_addr_out  = cpu_vram_addr;
            vram_wdata_out = cpu_wdata_q;
        end
    end

    // OAM port mux: DMA wins over the PPU scan, which wins over the CPU.
    always_comb begin
        oam_en_out    = 1'b0;
        oam_we_out    = 1'b0;
        oam_addr_out  = '0;
        oam_wdata_out = '0;
        if (dma_gnt) begin
            oam_en_out    = 1'b1;
            oam_we_out    = 1'b1;
            oam_addr_out  = dma_addr_in;
            oam_wdata_out = dma_wdata_in;
        end else if (ppu_oam_gnt) begin
            oam_en_out   = 1'b1;
            oam_addr_out = ppu_oam_addr_in;
        end else if (cpu_oam_go) begin
            oam_en_out    = 1'b1;
            oam_we_out    = cpu_we_q;
            oam_addr_out  = cpu_oam_addr;
            oam_wdata_out = cpu_wdata_q;
        end
    end

    // Control state and PPU valid pulses; reset aborts any access in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= S_IDLE;
            blocked_q        <= 1'b0;
            rdata_q          <= RD_BLOCKED;
            ppu_vram_valid_q <= 1'b0;
            ppu_oam_valid_q  <= 1'b0;
            ppu_oam_oob_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            blocked_q        <= blocked_d;
            rdata_q          <= rdata_d;
            ppu_vram_valid_q <= ppu_vram_gnt;
            ppu_oam_valid_q  <= ppu_oam_win;
            ppu_oam_oob_q    <= ~(ppu_oam_addr_in < OAM_SIZE);
        end
    end

    // Latched CPU request fields; only meaningful while the FSM is busy.
    always_ff @(posedge clk_in) begin
        cpu_addr_q  <= cpu_addr_d;
        cpu_we_q    <= cpu_we_d;
        cpu_wdata_q <= cpu_wdata_d;
    end

    assign cpu_rdata_out      = rdata_q;
    assign ppu_vram_valid_out = ppu_vram_valid_q;
    assign ppu_vram_data_out  = vram_rdata_in;
    assign ppu_oam_valid_out  = ppu_oam_valid_q;
    assign ppu_oam_data_out   = ppu_oam_oob_q ? RD_BLOCKED : oam_rdata_in;

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Directed bench for vram_oam_arbiter with behavioural VRAM/OAM models.
module tb_vram_oam_arbiter;

    localparam int VRAM_AW = 13;
    localparam int OAM_AW  = 8;
    localparam int DW      = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               lcd_en;
    logic [1:0]         mode;
    logic               cpu_req, cpu_we, cpu_ack;
    logic [15:0]        cpu_addr;
    logic [DW-1:0]      cpu_wdata, cpu_rdata;
    logic               ppu_vram_req, ppu_vram_valid;
    logic [VRAM_AW-1:0] ppu_vram_addr;
    logic [DW-1:0]      ppu_vram_data;
    logic               ppu_oam_req, ppu_oam_valid;
    logic [OAM_AW-1:0]  ppu_oam_addr;
    logic [DW-1:0]      ppu_oam_data;
    logic               dma_req;
    logic [OAM_AW-1:0]  dma_addr;
    logic [DW-1:0]      dma_wdata;
    logic               vram_en, vram_we;
    logic [VRAM_AW-1:0] vram_addr;
    logic [DW-1:0]      vram_wdata, vram_rdata;
    logic               oam_en, oam_we;
    logic [OAM_AW-1:0]  oam_addr;
    logic [DW-1:0]      oam_wdata, oam_rdata;

    vram_oam_arbiter #(.VRAM_AW(VRAM_AW), .OAM_AW(OAM_AW), .DW(DW)) dut (
        .clk_in(clk), .rst_in(rst), .lcd_en_in(lcd_en), .ppu_mode_in(mode),
        .cpu_req_in(cpu_req), .cpu_we_in(cpu_we), .cpu_addr_in(cpu_addr),
        .cpu_wdata_in(cpu_wdata), .cpu_ack_out(cpu_ack), .cpu_rdata_out(cpu_rdata),
        .ppu_vram_req_in(ppu_vram_req), .ppu_vram_addr_in(ppu_vram_addr),
        .ppu_vram_valid_out(ppu_vram_valid), .ppu_vram_data_out(ppu_vram_data),
        .ppu_oam_req_in(ppu_oam_req), .ppu_oam_addr_in(ppu_oam_addr),
        .ppu_oam_valid_out(ppu_oam_valid), .ppu_oam_data_out(ppu_oam_data),
        .dma_req_in(dma_req), .dma_addr_in(dma_addr), .dma_wdata_in(dma_wdata),
        .vram_en_out(vram_en), .vram_we_out(vram_we), .vram_addr_out(vram_addr),
        .vram_wdata_out(vram_wdata), .vram_rdata_in(vram_rdata),
        .oam_en_out(oam_en), .oam_we_out(oam_we), .oam_addr_out(oam_addr),
        .oam_wdata_out(oam_wdata), .oam_rdata_in(oam_rdata)
    );

    // Single-port synchronous memories with one cycle of read latency.
    logic [DW-1:0] vram_mem [0:8191];
    logic [DW-1:0] oam_mem  [0:255];
    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) vram_mem[vram_addr] <= vram_wdata;
            vram_rdata <= vram_mem[vram_addr];
        end
        if (oam_en) begin
            if (oam_we) oam_mem[oam_addr] <= oam_wdata;
            oam_rdata <= oam_mem[oam_addr];
        end
    end

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] rd;
    int         lat, wcyc;
    bit         any_v, any_o;

    // Issues one CPU access starting in the current cycle (N); lat is the ack cycle
    // relative to N, wcyc the first cycle with a VRAM write strobe. Ends one cycle
    // after the ack so the FSM is back in IDLE.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              output logic [7:0] r, output int l, output int wc,
                              output bit av, output bit ao);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        r = 8'h00; l = -1; wc = -1; av = 1'b0; ao = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (vram_en) av = 1'b1;
            if (vram_en && vram_we && wc < 0) wc = c;
            if (oam_en) ao = 1'b1;
            if (cpu_ack) begin
                l = c; r = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lcd_en = 1'b1; mode = 2'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        ppu_vram_req = 1'b1; ppu_vram_addr = '0;
        ppu_oam_req = 1'b1; ppu_oam_addr = 8'd1;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk); #1;
        tests_run++; if (vram_en !== 1'b0) begin fails++; $display("FAIL reset_vram_en: got %b want 0", vram_en); end
        tests_run++; if (oam_en !== 1'b0) begin fails++; $display("FAIL reset_oam_en: got %b want 0", oam_en); end
        tests_run++; if (ppu_vram_valid !== 1'b0) begin fails++; $display("FAIL reset_ppu_vram_valid: got %b want 0", ppu_vram_valid); end
        tests_run++; if (ppu_oam_valid !== 1'b0) begin fails++; $display("FAIL reset_ppu_oam_valid: got %b want 0", ppu_oam_valid); end
        tests_run++; if (cpu_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
        tests_run++; if (cpu_rdata !== 8'hFF) begin fails++; $display("FAIL reset_rdata: got %h want ff", cpu_rdata); end
        ppu_vram_req = 1'b0; ppu_oam_req = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vram_rw();
        lcd_en = 1'b1; mode = 2'd0;
        cpu_access(1'b1, 16'h8010, 8'h5A, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (lat !== 3) begin fails++; $display("FAIL vram_wr_latency: got %0d want 3", lat); end
        tests_run++; if (wcyc !== 1) begin fails++; $display("FAIL vram_wr_en_cycle: got %0d want 1", wcyc); end
        tests_run++; if (vram_mem[16] !== 8'h5A) begin fails++; $display("FAIL vram_wr_mem: got %h want 5a", vram_mem[16]); end
        cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (lat !== 3) begin fails++; $display("FAIL vram_rd_latency: got %0d want 3", lat); end
        tests_run++; if (rd !== 8'h5A) begin fails++; $display("FAIL vram_rd_data: got %h want 5a", rd); end
    endtask

    task automatic test_vram_lock();
        lcd_en = 1'b1; mode = 2'd3;
        cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (lat !== 3) begin fails++; $display("FAIL vlock_rd_latency: got %0d want 3", lat); end
        tests_run++; if (rd !== 8'hFF) begin fails++; $display("FAIL vlock_rd_data: got %h want ff", rd); end
        tests_run++; if (any_v !== 1'b0) begin fails++; $display("FAIL vlock_rd_en: got %b want 0", any_v); end
        cpu_access(1'b1, 16'h8010, 8'hA5, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (any_v !== 1'b0) begin fails++; $display("FAIL vlock_wr_en: got %b want 0", any_v); end
        tests_run++; if (vram_mem[16] !== 8'h5A) begin fails++; $display("FAIL vlock_wr_mem: got %h want 5a", vram_mem[16]); end
    endtask

    task automatic test_oam_lock();
        lcd_en = 1'b1; mode = 2'd0;
        cpu_access(1'b1, 16'hFE04, 8'h33, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (oam_mem[4] !== 8'h33) begin fails++; $display("FAIL oam_wr_mem: got %h want 33", oam_mem[4]); end
        mode = 2'd2;
        cpu_access(1'b0, 16'hFE04, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'hFF) begin fails++; $display("FAIL olock_rd_data: got %h want ff", rd); end
        tests_run++; if (any_o !== 1'b0) begin fails++; $display("FAIL olock_rd_en: got %b want 0", any_o); end
        lcd_en = 1'b0;
        cpu_access(1'b0, 16'hFE04, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'h33) begin fails++; $display("FAIL lcd_off_oam_rd: got %h want 33", rd); end
        mode = 2'd3;
        cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'h5A) begin fails++; $display("FAIL lcd_off_vram_rd: got %h want 5a", rd); end
        lcd_en = 1'b1; mode = 2'd0;
    endtask

    task automatic test_unmapped();
        lcd_en = 1'b1; mode = 2'd0;
        cpu_access(1'b0, 16'hC000, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'hFF || lat !== 3) begin fails++; $display("FAIL unmapped_rd: got %h lat %0d want ff lat 3", rd, lat); end
        tests_run++; if (any_v !== 1'b0 || any_o !== 1'b0) begin fails++; $display("FAIL unmapped_rd_en: got v%b o%b want 0 0", any_v, any_o); end
        cpu_access(1'b1, 16'hFEA0, 8'h77, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (any_o !== 1'b0) begin fails++; $display("FAIL oam_oob_wr_en: got %b want 0", any_o); end
        cpu_access(1'b0, 16'hFEA0, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'hFF) begin fails++; $display("FAIL oam_oob_rd: got %h want ff", rd); end
        ppu_oam_req = 1'b1; ppu_oam_addr = 8'd200;
        #1;
        tests_run++; if (oam_en !== 1'b0) begin fails++; $display("FAIL ppu_oam_oob_en: got %b want 0", oam_en); end
        @(posedge clk); #1;
        ppu_oam_req = 1'b0;
        tests_run++; if (ppu_oam_data !== 8'hFF) begin fails++; $display("FAIL ppu_oam_oob_data: got %h want ff", ppu_oam_data); end
    endtask

    task automatic test_dma();
        lcd_en = 1'b1; mode = 2'd0;
        fork
            begin
                for (int i = 0; i < 160; i++) begin
                    dma_req = 1'b1; dma_addr = 8'(i); dma_wdata = 8'(i);
                    @(posedge clk); #1;
                end
                dma_req = 1'b0;
            end
            begin
                repeat (10) @(posedge clk); #1;
                cpu_access(1'b0, 16'hFE05, 8'h00, rd, lat, wcyc, any_v, any_o);
                tests_run++; if (rd !== 8'hFF) begin fails++; $display("FAIL dma_cpu_rd: got %h want ff", rd); end
                tests_run++; if (lat !== 3) begin fails++; $display("FAIL dma_cpu_latency: got %0d want 3", lat); end
            end
            begin
                repeat (30) @(posedge clk); #1;
                ppu_oam_req = 1'b1; ppu_oam_addr = 8'd7;
                #1;
                tests_run++; if (oam_addr !== 8'd30 || oam_we !== 1'b1) begin fails++; $display("FAIL dma_priority: got addr %0d we %b want 30 1", oam_addr, oam_we); end
                @(posedge clk); #1;
                ppu_oam_req = 1'b0;
                tests_run++; if (ppu_oam_valid !== 1'b0) begin fails++; $display("FAIL dma_ppu_valid: got %b want 0", ppu_oam_valid); end
            end
        join
        tests_run++; if (oam_mem[0] !== 8'd0) begin fails++; $display("FAIL dma_mem0: got %h want 00", oam_mem[0]); end
        tests_run++; if (oam_mem[5] !== 8'd5) begin fails++; $display("FAIL dma_mem5: got %h want 05", oam_mem[5]); end
        tests_run++; if (oam_mem[159] !== 8'd159) begin fails++; $display("FAIL dma_mem159: got %h want 9f", oam_mem[159]); end
        cpu_access(1'b0, 16'hFE9F, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'h9F) begin fails++; $display("FAIL post_dma_cpu_rd: got %h want 9f", rd); end
        ppu_oam_req = 1'b1; ppu_oam_addr = 8'd7;
        @(posedge clk); #1;
        ppu_oam_req = 1'b0;
        tests_run++; if (ppu_oam_valid !== 1'b1 || ppu_oam_data !== 8'h07) begin fails++; $display("FAIL post_dma_ppu_rd: got v%b %h want v1 07", ppu_oam_valid, ppu_oam_data); end
    endtask

    task automatic test_back_to_back();
        lcd_en = 1'b1; mode = 2'd0;
        fork
            cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, wcyc, any_v, any_o);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    ppu_vram_req = 1'b1; ppu_vram_addr = 13'h0010;
                    if (k > 0) begin
                        tests_run++; if (ppu_vram_valid !== 1'b1 || ppu_vram_data !== 8'h5A) begin fails++; $display("FAIL ppu_vram_pulse_%0d: got v%b %h want v1 5a", k, ppu_vram_valid, ppu_vram_data); end
                    end
                end
                @(posedge clk); #1;
                ppu_vram_req = 1'b0;
                tests_run++; if (ppu_vram_valid !== 1'b1 || ppu_vram_data !== 8'h5A) begin fails++; $display("FAIL ppu_vram_pulse_3: got v%b %h want v1 5a", ppu_vram_valid, ppu_vram_data); end
                @(posedge clk); #1;
                tests_run++; if (ppu_vram_valid !== 1'b0) begin fails++; $display("FAIL ppu_vram_no_pulse: got %b want 0", ppu_vram_valid); end
            end
        join
        tests_run++; if (lat !== 6) begin fails++; $display("FAIL stall_latency: got %0d want 6", lat); end
        tests_run++; if (rd !== 8'h5A) begin fails++; $display("FAIL stall_rd_data: got %h want 5a", rd); end
    endtask

    task automatic test_reset_mid();
        int acks;
        lcd_en = 1'b1; mode = 2'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (cpu_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_ack: got %b want 0", cpu_ack); end
        tests_run++; if (cpu_rdata !== 8'hFF) begin fails++; $display("FAIL rst_mid_rdata: got %h want ff", cpu_rdata); end
        tests_run++; if (vram_en !== 1'b0) begin fails++; $display("FAIL rst_mid_vram_en: got %b want 0", vram_en); end
        #2 rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
        end
        tests_run++; if (acks !== 0) begin fails++; $display("FAIL rst_mid_late_ack: got %0d acks want 0", acks); end
        cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, wcyc, any_v, any_o);
        tests_run++; if (rd !== 8'h5A || lat !== 3) begin fails++; $display("FAIL rst_recover_rd: got %h lat %0d want 5a lat 3", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_vram_rw();
        test_vram_lock();
        test_oam_lock();
        test_unmapped();
        test_dma();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
